// File: rtl/vga_glyph_pkg.sv
// rtl/vga_glyph_pkg.sv - shared widths and requester ids for the VGA glyph renderer
package vga_glyph_pkg;
    localparam int DIV3_IN_W = 7;
    localparam int DIV3_Q_W  = 6;
    localparam int DIV3_R_W  = 2;

    localparam logic REQ_H = 1'b0;
    localparam logic REQ_V = 1'b1;
endpackage

// File: rtl/div3.sv
// rtl/div3.sv - combinational divide-by-three of a 7-bit value
module div3
    import vga_glyph_pkg::*;
(
    input  logic [DIV3_IN_W-1:0] dividend,
    output logic [DIV3_Q_W-1:0]  quotient
);
    logic [12:0] ext;
    logic [12:0] prod;

    // floor(x*43/128) equals floor(x/3) for every x in 0..127
    assign ext      = {6'd0, dividend};
    assign prod     = (ext << 5) + (ext << 3) + (ext << 1) + ext;
    assign quotient = DIV3_Q_W'(prod >> 7);
endmodule

// File: rtl/div3_share_arb.sv
// rtl/div3_share_arb.sv - arbiter sharing one div3 between horizontal and vertical requesters
module div3_share_arb
    import vga_glyph_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0,
    input  logic [DIV3_IN_W-1:0] in0,
    output logic                 gnt0,
    output logic                 valid0,
    output logic [DIV3_Q_W-1:0]  q0,
    output logic [DIV3_R_W-1:0]  r0,
    input  logic                 req1,
    input  logic [DIV3_IN_W-1:0] in1,
    output logic                 gnt1,
    output logic                 valid1,
    output logic [DIV3_Q_W-1:0]  q1,
    output logic [DIV3_R_W-1:0]  r1
);
    logic                 last;
    logic [DIV3_IN_W-1:0] sel_in;
    logic [DIV3_Q_W-1:0]  quo;
    logic [DIV3_IN_W-1:0] quo_ext;
    logic [DIV3_IN_W-1:0] diff;
    logic [DIV3_R_W-1:0]  rem;

    // last == REQ_V means requester 1 was served most recently, so 0 wins a tie
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n) begin
            if (req0 && req1) begin
                if (FIXED_PRIO != 0 || last == REQ_V) begin
                    gnt0 = 1'b1;
                end else begin
                    gnt1 = 1'b1;
                end
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    assign sel_in = gnt1 ? in1 : in0;

    div3 u_div3 (
        .dividend (sel_in),
        .quotient (quo)
    );

    assign quo_ext = {1'b0, quo};
    assign diff    = sel_in - (quo_ext << 1) - quo_ext;
    assign rem     = DIV3_R_W'(diff);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid0 <= 1'b0;
            valid1 <= 1'b0;
            q0     <= '0;
            r0     <= '0;
            q1     <= '0;
            r1     <= '0;
            last   <= REQ_V;
        end else begin
            valid0 <= gnt0;
            valid1 <= gnt1;
            if (gnt0) begin
                q0 <= quo;
                r0 <= rem;
            end
            if (gnt1) begin
                q1 <= quo;
                r1 <= rem;
            end
            if (gnt0 || gnt1) begin
                last <= gnt1 ? REQ_V : REQ_H;
            end
        end
    end
endmodule

// File: tb/tb_div3_share_arb.sv
// tb/tb_div3_share_arb.sv - scoreboard bench for div3_share_arb, round-robin and fixed-priority instances
module tb_div3_share_arb;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic [6:0] in0 = '0;
    logic [6:0] in1 = '0;

    logic       g0a, g1a, v0a, v1a, g0b, g1b, v0b, v1b;
    logic [5:0] q0a, q1a, q0b, q1b;
    logic [1:0] r0a, r1a, r0b, r1b;

    div3_share_arb #(.FIXED_PRIO(0)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .in0(in0), .gnt0(g0a), .valid0(v0a), .q0(q0a), .r0(r0a),
        .req1(req1), .in1(in1), .gnt1(g1a), .valid1(v1a), .q1(q1a), .r1(r1a)
    );

    div3_share_arb #(.FIXED_PRIO(1)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .in0(in0), .gnt0(g0b), .valid0(v0b), .q0(q0b), .r0(r0b),
        .req1(req1), .in1(in1), .gnt1(g1b), .valid1(v1b), .q1(q1b), .r1(r1b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int d;
        int k;
        int due;
        int q;
        int r;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    int   hold_q[2][2];
    int   hold_r[2][2];
    int   last_m[2];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic get_out(input int d, input int k, output int v, output int q, output int r);
        case ({d[0], k[0]})
            2'b00: begin v = int'(v0a); q = int'(q0a); r = int'(r0a); end
            2'b01: begin v = int'(v1a); q = int'(q1a); r = int'(r1a); end
            2'b10: begin v = int'(v0b); q = int'(q0b); r = int'(r0b); end
            default: begin v = int'(v1b); q = int'(q1b); r = int'(r1b); end
        endcase
    endtask

    task automatic get_gnt(input int d, output int ga, output int gb);
        if (d == 0) begin
            ga = int'(g0a); gb = int'(g1a);
        end else begin
            ga = int'(g0b); gb = int'(g1b);
        end
    endtask

    // Reference: at most one winner per cycle; ties go to 0 under fixed priority,
    // otherwise to whichever requester did not win the previous grant.
    task automatic step(input bit rs, input bit r0, input int i0, input bit r1, input int i1);
        int win, ga, gb, dv;
        @(posedge clk);
        #1;
        rst_n = rs; req0 = r0; req1 = r1;
        in0 = 7'(i0); in1 = 7'(i1);
        #1;
        for (int d = 0; d < 2; d++) begin
            win = -1;
            if (rs) begin
                if (r0 && r1) win = (d == 1) ? 0 : (last_m[d] == 0 ? 1 : 0);
                else if (r0) win = 0;
                else if (r1) win = 1;
            end
            get_gnt(d, ga, gb);
            chk(d == 0 ? "rr_gnt0" : "fp_gnt0", ga, win == 0 ? 1 : 0);
            chk(d == 0 ? "rr_gnt1" : "fp_gnt1", gb, win == 1 ? 1 : 0);
            if (win >= 0) begin
                dv = (win == 0) ? i0 : i1;
                sb.push_back('{d: d, k: win, due: cyc + 1, q: dv / 3, r: dv % 3});
                last_m[d] = win;
            end
            if (!rs) last_m[d] = 1;
        end
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            for (int d = 0; d < 2; d++)
                for (int k = 0; k < 2; k++) begin
                    hold_q[d][k] = 0;
                    hold_r[d][k] = 0;
                end
        end
    end

    always @(negedge clk) begin
        int v, q, r, idx;
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                for (int k = 0; k < 2; k++) begin
                    get_out(d, k, v, q, r);
                    idx = -1;
                    for (int i = 0; i < sb.size(); i++) begin
                        if (sb[i].d == d && sb[i].k == k && sb[i].due == cyc) begin
                            idx = i;
                            break;
                        end
                    end
                    chk($sformatf("valid d%0d k%0d", d, k), v, idx >= 0 ? 1 : 0);
                    if (idx >= 0) begin
                        hold_q[d][k] = sb[idx].q;
                        hold_r[d][k] = sb[idx].r;
                        sb.delete(idx);
                    end
                    chk($sformatf("q d%0d k%0d", d, k), q, hold_q[d][k]);
                    chk($sformatf("r d%0d k%0d", d, k), r, hold_r[d][k]);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit p0, p1;
        int a0, a1;
        for (int d = 0; d < 2; d++) begin
            last_m[d] = 1;
            for (int k = 0; k < 2; k++) begin
                hold_q[d][k] = 0;
                hold_r[d][k] = 0;
            end
        end

        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        mon_en = 1'b1;
        step(0, 0, 0, 0, 0);

        // single request then idle hold
        step(1, 1, 127, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0);

        // requester 1 sweeps every dividend back-to-back
        for (int i = 0; i < 128; i++) step(1, 0, 0, 1, i);
        step(1, 0, 0, 0, 0);

        // sustained contention
        for (int i = 0; i < 8; i++) step(1, 1, 9, 1, 100);
        step(1, 0, 0, 1, 100);
        step(1, 0, 0, 0, 0);

        // reset lands while requester 1 asks, then a tie right after release
        step(1, 0, 0, 1, 77);
        step(0, 0, 0, 1, 50);
        step(1, 1, 5, 1, 7);
        step(1, 1, 8, 1, 7);
        step(1, 0, 0, 0, 0);

        // randomized traffic, requests held until the round-robin instance grants
        p0 = 0; p1 = 0; a0 = 0; a1 = 0;
        for (int i = 0; i < 400; i++) begin
            if (!p0) begin
                p0 = ($urandom_range(0, 99) < 60);
                a0 = $urandom_range(0, 127);
            end
            if (!p1) begin
                p1 = ($urandom_range(0, 99) < 60);
                a1 = $urandom_range(0, 127);
            end
            if ($urandom_range(0, 99) < 2) begin
                step(0, p0, a0, p1, a1);
                p0 = 0; p1 = 0;
            end else begin
                step(1, p0, a0, p1, a1);
                p0 = p0 && !g0a;
                p1 = p1 && !g1a;
            end
        end

        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
